name_seg_encoder: RTL and testbench
===================================

# name_seg_encoder

Reverse-direction companion to the name-letter segment decoder. Takes a 7-segment pattern stream, active-low, with bit k driving segment k (bit 0 = a, bit 6 = g). It requires each pattern to be stable for a programmable number of strobes, then encodes the pattern back into the 4-bit name-character code. It sits on the display-side bus, either for loopback checking of the decoder path or for capturing patterns from an external display source, and reports one registered result per accepted pattern.

## Interface
- STABLE_CNT, 4, consecutive identical strobed samples required before acceptance; legal 1..15.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- seg_in  in  7  segment pattern (active-low, bit k = segment k).
- seg_stb  in  1  sample qualifier; seg_in is sampled on each clk edge with seg_stb=1.
- code  out  4  encoded character code; holds until the next acceptance.
- code_valid  out  1  one-cycle pulse marking a new acceptance.
- code_err  out  1  the last accepted pattern is not in the table and is not blank.
- blank  out  1  the last accepted pattern is all-off (7'h7F).
- locked  out  1  FSM is in LOCKED.
- err_cnt  out  8  saturating count of accepted unmatched patterns.

## Operation
Encode table, pattern to code:
- 7'h41 -> 0, 7'h06 -> 1, 7'h4E -> 2, 7'h10 -> 3, 7'h08 -> 4
- 7'h12 -> 5, 7'h79 -> 6, 7'h48 -> 7, 7'h40 -> 8
- 7'h7F -> code 4'hF, blank=1
- any other pattern -> code 4'hE, code_err=1

Internal state:
- last_pat (7 bits), reset value 7'h7F.
- stab_cnt (4 bits), reset value 0.
- FSM with states SEARCH and LOCKED; reset state SEARCH.

On each strobe:
- If seg_in == last_pat, new_cnt = min(stab_cnt+1, STABLE_CNT).
- Otherwise last_pat <= seg_in and new_cnt = 1.
- stab_cnt <= new_cnt.

FSM transitions:
- SEARCH, strobe with new_cnt == STABLE_CNT: accept, go to LOCKED.
- LOCKED, strobe with seg_in == last_pat: no action.
- LOCKED, strobe with seg_in != last_pat: go to SEARCH with new_cnt=1. If STABLE_CNT=1, accept immediately and stay LOCKED.
- No strobe: state and counters hold.

On accept, all of the following are registered on the same edge:
- code, code_err and blank are loaded from the table lookup of seg_in.
- code_valid is set to 1 for exactly one cycle.
- err_cnt increments, saturating at 255, when the pattern is unmatched.

Repeated identical patterns in LOCKED never re-emit.

## Timing
- Reset (asynchronous, immediate): code=0, code_valid=0, code_err=0, blank=0, locked=0, err_cnt=0, FSM=SEARCH, stab_cnt=0, last_pat=7'h7F.
- Latency: code_valid and the result fields are high in the cycle after the clk edge that sampled the STABLE_CNT-th identical strobe.
- With seg_stb held high, one sample is taken per clk. Minimum acceptance period is STABLE_CNT cycles per pattern.
- Strobes do not need to be contiguous; gaps without a strobe neither reset nor advance stab_cnt.
- First pattern after reset needs the full STABLE_CNT strobes. This includes 7'h7F, because stab_cnt starts at 0.
- Reset mid-count discards all partial progress. Reset coincident with a would-be acceptance produces no pulse.
- Once err_cnt reaches 255 it holds; it clears only on rst.

## Test plan
- STABLE_CNT=4, four strobes of 7'h4E -> one code_valid pulse the cycle after the 4th edge with code=2, code_err=0, locked=1. Eight further strobes of 7'h4E -> no pulse.
- Three strobes of 7'h79, then four strobes of 7'h41 -> exactly one pulse, with code=0. No pulse for code 6.
- Four strobes of 7'h2A -> code=4'hE, code_err=1, err_cnt=1. Alternating 7'h2A/7'h2B bursts of four, 300 times -> err_cnt=255 and stays there.
- After reset, four strobes of 7'h7F -> pulse with blank=1, code=4'hF, code_err=0.
- Two strobes of 7'h08, assert rst for one cycle, then two strobes of 7'h08 -> no pulse, and all outputs are 0 during reset. Two more strobes of 7'h08 -> pulse with code=4.
- STABLE_CNT=1, sweep the nine table patterns one strobe each with gaps -> nine pulses, codes 0..8 in order, code_err=0 throughout.

Source files
------------

// File: rtl/name_seg_encoder_if.sv
// rtl/name_seg_encoder_if.sv - segment pattern input and encoded result bus
interface name_seg_encoder_if;
    logic [6:0] seg_in;
    logic       seg_stb;
    logic [3:0] code;
    logic       code_valid;
    logic       code_err;
    logic       blank;
    logic       locked;
    logic [7:0] err_cnt;

    modport master (
        output seg_in, seg_stb,
        input  code, code_valid, code_err, blank, locked, err_cnt
    );

    modport slave (
        input  seg_in, seg_stb,
        output code, code_valid, code_err, blank, locked, err_cnt
    );
endinterface

// File: rtl/name_seg_encoder.sv
// rtl/name_seg_encoder.sv - debounced 7-segment pattern to name-character code encoder
module name_seg_encoder #(
    parameter int STABLE_CNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    name_seg_encoder_if.slave  bus
);
    localparam logic [3:0] STABLE = 4'(STABLE_CNT);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t     state_q, state_d;
    logic [6:0] last_pat_q, last_pat_d;
    logic [3:0] stab_cnt_q, stab_cnt_d;
    logic [3:0] code_q, code_d;
    logic       code_valid_q, code_valid_d;
    logic       code_err_q, code_err_d;
    logic       blank_q, blank_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic       same;
    logic       accept;
    logic [3:0] new_cnt;
    logic [3:0] lut_code;
    logic       lut_err;
    logic       lut_blank;

    // Patterns are active-low: a cleared bit lights the segment.
    always_comb begin
        lut_code  = 4'hE;
        lut_err   = 1'b0;
        lut_blank = 1'b0;
        case (bus.seg_in)
            7'h41:   lut_code = 4'd0;
            7'h06:   lut_code = 4'd1;
            7'h4E:   lut_code = 4'd2;
            7'h10:   lut_code = 4'd3;
            7'h08:   lut_code = 4'd4;
            7'h12:   lut_code = 4'd5;
            7'h79:   lut_code = 4'd6;
            7'h48:   lut_code = 4'd7;
            7'h40:   lut_code = 4'd8;
            7'h7F: begin
                lut_code  = 4'hF;
                lut_blank = 1'b1;
            end
            default: lut_err = 1'b1;
        endcase
    end

    always_comb begin
        same = (bus.seg_in == last_pat_q);
        if (!same)
            new_cnt = 4'd1;
        else if (stab_cnt_q >= STABLE)
            new_cnt = STABLE;
        else
            new_cnt = stab_cnt_q + 4'd1;
    end

    always_comb begin
        state_d      = state_q;
        last_pat_d   = last_pat_q;
        stab_cnt_d   = stab_cnt_q;
        code_d       = code_q;
        code_err_d   = code_err_q;
        blank_d      = blank_q;
        err_cnt_d    = err_cnt_q;
        code_valid_d = 1'b0;
        accept       = 1'b0;

        if (bus.seg_stb) begin
            last_pat_d = bus.seg_in;
            stab_cnt_d = new_cnt;
            case (state_q)
                SEARCH: begin
                    if (new_cnt == STABLE) begin
                        accept  = 1'b1;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    // A new pattern restarts the count; with a threshold of one it is already stable.
                    if (!same) begin
                        if (STABLE == 4'd1)
                            accept = 1'b1;
                        else
                            state_d = SEARCH;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        if (accept) begin
            code_valid_d = 1'b1;
            code_d       = lut_code;
            code_err_d   = lut_err;
            blank_d      = lut_blank;
            if (lut_err && err_cnt_q != 8'hFF)
                err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SEARCH;
            last_pat_q   <= 7'h7F;
            stab_cnt_q   <= 4'd0;
            code_q       <= 4'd0;
            code_valid_q <= 1'b0;
            code_err_q   <= 1'b0;
            blank_q      <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_pat_q   <= last_pat_d;
            stab_cnt_q   <= stab_cnt_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            code_err_q   <= code_err_d;
            blank_q      <= blank_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.code       = code_q;
    assign bus.code_valid = code_valid_q;
    assign bus.code_err   = code_err_q;
    assign bus.blank      = blank_q;
    assign bus.locked     = (state_q == LOCKED);
    assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_name_seg_encoder.sv
// tb/tb_name_seg_encoder.sv - self-checking bench for name_seg_encoder
module tb_name_seg_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    name_seg_encoder_if bus4();
    name_seg_encoder_if bus1();

    name_seg_encoder #(.STABLE_CNT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    name_seg_encoder #(.STABLE_CNT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    localparam logic [6:0] TBL [9] = '{7'h41, 7'h06, 7'h4E, 7'h10, 7'h08,
                                       7'h12, 7'h79, 7'h48, 7'h40};

    int checks   = 0;
    int failures = 0;

    // Reference: a pattern is accepted when its run of identical strobes first reaches N.
    int         m_n     [2] = '{4, 1};
    logic [6:0] m_pat   [2];
    int         m_len   [2];
    logic       m_valid [2];
    logic [3:0] m_code  [2];
    logic       m_err   [2];
    logic       m_blank [2];
    int         m_errcnt[2];

    typedef struct {
        logic       stb;
        logic [6:0] pat;
        logic       v;
        logic [3:0] code;
        logic       err;
        logic       locked;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic void lookup(input logic [6:0] p, output logic [3:0] c,
                                   output logic e, output logic b);
        c = 4'hE; e = 1'b1; b = 1'b0;
        if (p == 7'h7F) begin
            c = 4'hF; e = 1'b0; b = 1'b1;
        end else begin
            for (int i = 0; i < 9; i++)
                if (TBL[i] == p) begin
                    c = 4'(i); e = 1'b0;
                end
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pat[k] = 7'h7F; m_len[k] = 0; m_valid[k] = 1'b0;
            m_code[k] = 4'd0; m_err[k] = 1'b0; m_blank[k] = 1'b0; m_errcnt[k] = 0;
        end
    endfunction

    function automatic void model_step(input logic stb, input logic [6:0] pat);
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            if (stb) begin
                if (pat == m_pat[k]) m_len[k]++;
                else begin
                    m_pat[k] = pat; m_len[k] = 1;
                end
                if (m_len[k] == m_n[k]) begin
                    m_valid[k] = 1'b1;
                    lookup(pat, m_code[k], m_err[k], m_blank[k]);
                    if (m_err[k] && m_errcnt[k] < 255) m_errcnt[k]++;
                end
            end
        end
    endfunction

    task automatic check_model();
        chk("d4.code_valid", {7'd0, bus4.code_valid}, {7'd0, m_valid[0]});
        chk("d4.code",       {4'd0, bus4.code},       {4'd0, m_code[0]});
        chk("d4.code_err",   {7'd0, bus4.code_err},   {7'd0, m_err[0]});
        chk("d4.blank",      {7'd0, bus4.blank},      {7'd0, m_blank[0]});
        chk("d4.locked",     {7'd0, bus4.locked},     {7'd0, m_len[0] >= m_n[0]});
        chk("d4.err_cnt",    bus4.err_cnt,            8'(m_errcnt[0]));
        chk("d1.code_valid", {7'd0, bus1.code_valid}, {7'd0, m_valid[1]});
        chk("d1.code",       {4'd0, bus1.code},       {4'd0, m_code[1]});
        chk("d1.code_err",   {7'd0, bus1.code_err},   {7'd0, m_err[1]});
        chk("d1.blank",      {7'd0, bus1.blank},      {7'd0, m_blank[1]});
        chk("d1.locked",     {7'd0, bus1.locked},     {7'd0, m_len[1] >= m_n[1]});
        chk("d1.err_cnt",    bus1.err_cnt,            8'(m_errcnt[1]));
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs checked.
    task automatic cycle(input logic stb, input logic [6:0] pat);
        bus4.seg_stb = stb; bus4.seg_in = pat;
        bus1.seg_stb = stb; bus1.seg_in = pat;
        @(posedge clk);
        model_step(stb, pat);
        @(negedge clk);
        check_model();
    endtask

    task automatic check_reset_outputs();
        chk("rst.d4.code",       {4'd0, bus4.code},       8'd0);
        chk("rst.d4.code_valid", {7'd0, bus4.code_valid}, 8'd0);
        chk("rst.d4.code_err",   {7'd0, bus4.code_err},   8'd0);
        chk("rst.d4.blank",      {7'd0, bus4.blank},      8'd0);
        chk("rst.d4.locked",     {7'd0, bus4.locked},     8'd0);
        chk("rst.d4.err_cnt",    bus4.err_cnt,            8'd0);
        chk("rst.d1.err_cnt",    bus1.err_cnt,            8'd0);
    endtask

    // Reset held across one rising edge while a strobe is presented.
    task automatic do_reset(input logic [6:0] pat);
        bus4.seg_stb = 1'b1; bus4.seg_in = pat;
        bus1.seg_stb = 1'b1; bus1.seg_in = pat;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        model_reset();
    endtask

    function automatic void add(input logic stb, input logic [6:0] pat, input logic v,
                                input logic [3:0] code, input logic err, input logic locked);
        vec_t x;
        x.stb = stb; x.pat = pat; x.v = v; x.code = code; x.err = err; x.locked = locked;
        vecs.push_back(x);
    endfunction

    function automatic logic [6:0] pick();
        int r = $urandom_range(0, 11);
        if (r < 9) return TBL[r];
        if (r == 9) return 7'h7F;
        return 7'($urandom);
    endfunction

    initial begin
        logic [6:0] cur;
        int pulses;

        bus4.seg_stb = 1'b0; bus4.seg_in = 7'h7F;
        bus1.seg_stb = 1'b0; bus1.seg_in = 7'h7F;
        model_reset();
        @(negedge clk);
        do_reset(7'h00);

        add(1, 7'h4E, 0, 4'd0, 0, 0);
        add(1, 7'h4E, 0, 4'd0, 0, 0);
        add(0, 7'h7F, 0, 4'd0, 0, 0);
        add(1, 7'h4E, 0, 4'd0, 0, 0);
        add(1, 7'h4E, 1, 4'd2, 0, 1);
        for (int i = 0; i < 8; i++) add(1, 7'h4E, 0, 4'd2, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 7'h79, 0, 4'd2, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 7'h41, 0, 4'd2, 0, 0);
        add(1, 7'h41, 1, 4'd0, 0, 1);
        add(0, 7'h41, 0, 4'd0, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 7'h2A, 0, 4'd0, 0, 0);
        add(1, 7'h2A, 1, 4'hE, 1, 1);

        foreach (vecs[i]) begin
            cycle(vecs[i].stb, vecs[i].pat);
            chk($sformatf("vec%0d.valid", i),  {7'd0, bus4.code_valid}, {7'd0, vecs[i].v});
            chk($sformatf("vec%0d.code", i),   {4'd0, bus4.code},       {4'd0, vecs[i].code});
            chk($sformatf("vec%0d.err", i),    {7'd0, bus4.code_err},   {7'd0, vecs[i].err});
            chk($sformatf("vec%0d.locked", i), {7'd0, bus4.locked},     {7'd0, vecs[i].locked});
        end
        chk("err_cnt_one", bus4.err_cnt, 8'd1);

        for (int b = 0; b < 300; b++)
            for (int j = 0; j < 4; j++) cycle(1'b1, b[0] ? 7'h2B : 7'h2A);
        chk("err_cnt_sat", bus4.err_cnt, 8'd255);
        for (int j = 0; j < 4; j++) cycle(1'b1, 7'h2C);
        chk("err_cnt_hold", bus4.err_cnt, 8'd255);

        do_reset(7'h7F);
        for (int j = 0; j < 4; j++) cycle(1'b1, 7'h7F);
        chk("blank.valid", {7'd0, bus4.code_valid}, 8'd1);
        chk("blank.blank", {7'd0, bus4.blank},      8'd1);
        chk("blank.code",  {4'd0, bus4.code},       8'h0F);
        chk("blank.err",   {7'd0, bus4.code_err},   8'd0);

        do_reset(7'h00);
        cycle(1'b1, 7'h08);
        cycle(1'b1, 7'h08);
        cycle(1'b1, 7'h08);
        do_reset(7'h08);
        pulses = 0;
        for (int j = 0; j < 3; j++) begin
            cycle(1'b1, 7'h08);
            pulses += int'(bus4.code_valid);
        end
        chk("rst_mid.no_pulse", 8'(pulses), 8'd0);
        cycle(1'b1, 7'h08);
        chk("rst_mid.valid", {7'd0, bus4.code_valid}, 8'd1);
        chk("rst_mid.code",  {4'd0, bus4.code},       8'd4);

        do_reset(7'h00);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, TBL[i]);
            pulses += int'(bus1.code_valid);
            chk($sformatf("sweep%0d.code", i), {4'd0, bus1.code},     8'(i));
            chk($sformatf("sweep%0d.err", i),  {7'd0, bus1.code_err}, 8'd0);
            cycle(1'b0, 7'h00);
        end
        chk("sweep.pulses", 8'(pulses), 8'd9);

        cur = pick();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) cur = pick();
            if (i == 700) do_reset(cur);
            cycle($urandom_range(0, 3) != 0, cur);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
